// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an output-stationary systolic array: clear, skewed feed, drain, row-by-row result handout.
// Optional build macro SYSTOLIC_TILE_PERF_EN adds perf_cycles / perf_stall counters.
//
// state  | meaning
// IDLE   | waiting for a job, start_ready high
// CLEAR  | one-cycle accumulator clear
// FEED   | skewed operand injection, t = 0..K+ROWS+COLS-3
// DRAIN  | one cycle for the last accumulate to land
// RESULT | one row per res_valid & res_ready beat
module systolic_tile_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 16,
    parameter int T_W  = 17,
    localparam int RR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 start_ready,
    output logic                 clear_all,
    output logic [T_W-1:0]       feed_t,
    output logic                 feed_active,
    output logic [ROWS-1:0]      row_feed_en,
    output logic [COLS-1:0]      col_feed_en,
    output logic [ROWS*COLS-1:0] pe_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 res_valid,
    output logic [RR_W-1:0]      res_row,
    input  logic                 res_ready
`ifdef SYSTOLIC_TILE_PERF_EN
    ,
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stall
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam int TX = T_W + 1;

    logic [2:0]      state;
    logic [K_W-1:0]  k_lat;
    logic [T_W-1:0]  t;
    logic [RR_W-1:0] row_q;
    logic            done_q;

    // One extra bit so t - offset and K + skew never wrap in the compares.
    logic [TX-1:0] t_x, k_x, last_x;
    assign t_x    = TX'(t);
    assign k_x    = TX'(k_lat);
    assign last_x = k_x + TX'(ROWS + COLS - 2) - TX'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            k_lat  <= '0;
            t      <= '0;
            row_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_DRAIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    t     <= '0;
                    state <= (k_lat == '0) ? S_DRAIN : S_FEED;
                end
                S_FEED: begin
                    if (t_x == last_x) begin
                        t     <= '0;
                        state <= S_DRAIN;
                    end else begin
                        t <= t + T_W'(1);
                    end
                end
                S_DRAIN: begin
                    row_q <= '0;
                    state <= S_RESULT;
                end
                S_RESULT: begin
                    if (res_ready) begin
                        if (row_q == RR_W'(ROWS - 1)) begin
                            row_q <= '0;
                            state <= S_IDLE;
                        end else begin
                            row_q <= row_q + RR_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (state == S_IDLE);
    assign clear_all   = (state == S_CLEAR);
    assign feed_active = (state == S_FEED);
    assign feed_t      = t;
    assign busy        = (state != S_IDLE);
    assign done        = done_q;
    assign res_valid   = (state == S_RESULT);
    assign res_row     = row_q;

    // Cell (i,j) sees a[i][t-i-j] and b[t-i-j][j] together, so its window is skewed by i+j.
    always_comb begin
        row_feed_en = '0;
        col_feed_en = '0;
        pe_valid    = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < ROWS; i++)
                row_feed_en[i] = (t_x >= TX'(i)) && ((t_x - TX'(i)) < k_x);
            for (int j = 0; j < COLS; j++)
                col_feed_en[j] = (t_x >= TX'(j)) && ((t_x - TX'(j)) < k_x);
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    pe_valid[i*COLS+j] = (t_x >= TX'(i + j)) && ((t_x - TX'(i + j)) < k_x);
        end
    end

`ifdef SYSTOLIC_TILE_PERF_EN
    logic perf_count_en;
    // Includes the done cycle, so the final value equals the start-to-done latency.
    assign perf_count_en = (state != S_IDLE) && ((state != S_RESULT) || done_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (start && (state == S_IDLE)) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (perf_count_en && (perf_cycles != 32'hFFFF_FFFF))
                perf_cycles <= perf_cycles + 32'd1;
            if ((state == S_RESULT) && !res_ready && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Scoreboard bench for systolic_tile_ctrl (2x2 array): feed vectors and result rows are queued
// by the stimulus and checked by a negedge monitor; timing checks are done inline.
module tb_systolic_tile_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int K_W  = 16;
    localparam int T_W  = 17;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [K_W-1:0]       k_len;
    logic                 start_ready;
    logic                 clear_all;
    logic [T_W-1:0]       feed_t;
    logic                 feed_active;
    logic [ROWS-1:0]      row_feed_en;
    logic [COLS-1:0]      col_feed_en;
    logic [ROWS*COLS-1:0] pe_valid;
    logic                 busy;
    logic                 done;
    logic                 res_valid;
    logic [0:0]           res_row;
    logic                 res_ready;
`ifdef SYSTOLIC_TILE_PERF_EN
    logic [31:0]          perf_cycles;
    logic [31:0]          perf_stall;
`endif

    systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .T_W(T_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .start_ready(start_ready), .clear_all(clear_all), .feed_t(feed_t),
        .feed_active(feed_active), .row_feed_en(row_feed_en), .col_feed_en(col_feed_en),
        .pe_valid(pe_valid), .busy(busy), .done(done), .res_valid(res_valid),
        .res_row(res_row), .res_ready(res_ready)
`ifdef SYSTOLIC_TILE_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {feed_t, row_feed_en, col_feed_en, pe_valid} expected per FEED cycle
    logic [24:0] fq[$];
    int          rq[$];

    // Hand-computed {row[1:0], col[1:0], pe[3:0]} per t for a 2x2 array.
    localparam logic [7:0] K3_TAB [0:4] = '{8'b01_01_0001, 8'b11_11_0111, 8'b11_11_1111,
                                           8'b10_10_1110, 8'b00_00_1000};
    localparam logic [7:0] K1_TAB [0:2] = '{8'b01_01_0001, 8'b10_10_0110, 8'b00_00_1000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (feed_active) begin
            checks++;
            if (fq.size() == 0) begin
                errors++;
                $display("FAIL feed_unexpected: got t=%0d expected no feed", feed_t);
            end else begin
                logic [24:0] e;
                e = fq.pop_front();
                if ({feed_t, row_feed_en, col_feed_en, pe_valid} !== e) begin
                    errors++;
                    $display("FAIL feed_vec: got %h expected %h",
                             {feed_t, row_feed_en, col_feed_en, pe_valid}, e);
                end
            end
        end else begin
            chk("idle_enables", {24'd0, row_feed_en, col_feed_en, pe_valid}, 32'd0);
        end
        if (res_valid && res_ready) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL res_unexpected: got row %0d expected no beat", res_row);
            end else begin
                int e;
                e = rq.pop_front();
                if (32'(res_row) !== 32'(e)) begin
                    errors++;
                    $display("FAIL res_row: got %0d expected %0d", res_row, e);
                end
            end
        end
    end

    task automatic push_k3(input int n);
        for (int t = 0; t < n; t++) fq.push_back({17'(t), K3_TAB[t]});
    endtask

    task automatic launch(input int k);
        k_len = K_W'(k);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called one cycle after acceptance (CLEAR); n counts cycles since acceptance.
    task automatic wait_done(output int n);
        n = 1;
        chk("clear_pulse", {31'd0, clear_all}, 32'd1);
        chk("clear_feed_t", 32'(feed_t), 32'd0);
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!done) chk("clear_once", {31'd0, clear_all}, 32'd0);
        end
    endtask

    task automatic drain_results();
        int n;
        n = 0;
        res_ready = 1'b1;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        res_ready = 1'b0;
        chk("back_to_idle", {31'd0, start_ready}, 32'd1);
    endtask

    task automatic chk_reset_state(input string nm);
        chk(nm, {26'd0, start_ready, clear_all, feed_active, busy, done, res_valid}, 32'b100000);
        chk({nm, "_vec"}, {feed_t, row_feed_en, col_feed_en, pe_valid, res_row}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; k_len = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // K=3: done 8 cycles after acceptance, then result handshake 1,0,1
        push_k3(5);
        rq.push_back(0); rq.push_back(1);
        launch(3);
        wait_done(n);
        chk("latency_k3", n, 8);
        chk("res_first", {30'd0, res_valid, res_row}, 32'b10);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("res_row_adv", {30'd0, res_valid, res_row}, 32'b11);
        @(posedge clk); #1;
        chk("res_row_hold", {30'd0, res_valid, res_row}, 32'b11);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("end_k3", {29'd0, start_ready, res_valid, busy}, 32'b100);
`ifdef SYSTOLIC_TILE_PERF_EN
        chk("perf_cycles", perf_cycles, 32'd8);
        chk("perf_stall", perf_stall, 32'd1);
`endif

        // K=0: no feed cycles, still hands out two rows
        rq.push_back(0); rq.push_back(1);
        launch(0);
        wait_done(n);
        chk("latency_k0", n, 3);
        drain_results();

        // start during FEED is ignored; reset at t=2 kills the job
        push_k3(3);
        launch(3);
        @(posedge clk); #1;
        start = 1'b1; k_len = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ignore_start_ready", {31'd0, start_ready}, 32'd0);
        chk("ignore_start_t", 32'(feed_t), 32'd1);
        @(posedge clk); #1;
        chk("feed_t2", 32'(feed_t), 32'd2);
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midjob_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_state("after_reset");

        // K=1 job after reset
        for (int t = 0; t < 3; t++) fq.push_back({17'(t), K1_TAB[t]});
        rq.push_back(0); rq.push_back(1);
        launch(1);
        wait_done(n);
        chk("latency_k1", n, 6);
        drain_results();

        repeat (2) @(posedge clk); #1;
        chk("feed_q_empty", fq.size(), 32'd0);
        chk("res_q_empty", rq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
